// File: rtl/pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_subtractor
//
// Purpose:
//   Segmented, pipelined unsigned subtractor: o = (a - b) mod 2^WIDTH, with a
//   borrow flag that is set when a < b. The borrow chain is cut into SEG-bit
//   segments, and each register stage resolves one segment. The longest
//   combinational path therefore spans a single SEG-bit subtract.
//
// Parameters:
//   WIDTH   operand/result width in bits
//   SEG     bits resolved per stage (WIDTH % SEG must be 0)
//   STAGES  WIDTH/SEG, pipeline depth = latency in cycles
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      a/b valid this cycle
//   in_ready    out  1      block accepts a/b this cycle
//   a           in   WIDTH  minuend, unsigned
//   b           in   WIDTH  subtrahend, unsigned
//   out_valid   out  1      o/borrow_out valid
//   out_ready   in   1      downstream accepts result
//   o           out  WIDTH  (a - b) mod 2^WIDTH
//   borrow_out  out  1      1 iff a < b
//
// Handshake:
//   Both sides follow valid/ready. A transfer happens on a rising edge where
//   valid and ready are both high. Once valid is raised, the payload is held
//   stable until that transfer. The pipe uses a global stall: every stage
//   advances when the output slot is empty or is being drained
//   (advance = !out_valid || out_ready). in_ready is exactly that advance
//   signal, so one result can leave and a new operand pair can enter on the
//   same edge.
//
// Data movement:
//   Each stage shifts its operand copies right by SEG. The segment a stage
//   works on is therefore always at bits [SEG-1:0]; this is the input skew.
//   Finished result segments enter at the top of a result shift register
//   and move down one segment per stage; this is the output de-skew. After
//   STAGES stages, segment 0 has reached bit 0 and the result is in place.
// -----------------------------------------------------------------------------
module pipelined_subtractor #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             borrow_out
);

  localparam int STAGES = WIDTH / SEG;

  generate
    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_bad_seg
      $error("pipelined_subtractor: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
    end
  endgenerate

  // Stage registers
  logic             r_vld [STAGES];
  logic             r_brw [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_res [STAGES];

  // Per-stage inputs (from the ports for stage 0, else from the previous stage)
  logic             w_src_vld [STAGES];
  logic             w_src_bin [STAGES];
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [WIDTH-1:0] w_src_res [STAGES];

  // Per-stage next-state values
  logic [SEG-1:0]   w_diff     [STAGES];
  logic             w_bout     [STAGES];
  logic [WIDTH-1:0] w_a_next   [STAGES];
  logic [WIDTH-1:0] w_b_next   [STAGES];
  logic [WIDTH-1:0] w_res_next [STAGES];

  logic w_advance;

  assign w_advance = !r_vld[STAGES-1] || out_ready;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_src_vld[k] = in_valid;
        assign w_src_bin[k] = 1'b0;
        assign w_src_a[k]   = a;
        assign w_src_b[k]   = b;
        assign w_src_res[k] = '0;
      end else begin : g_body
        assign w_src_vld[k] = r_vld[k-1];
        assign w_src_bin[k] = r_brw[k-1];
        assign w_src_a[k]   = r_a[k-1];
        assign w_src_b[k]   = r_b[k-1];
        assign w_src_res[k] = r_res[k-1];
      end

      // One SEG-bit subtract with borrow-in. The extra top bit catches the
      // borrow-out. This is the only carry path inside a stage.
      assign {w_bout[k], w_diff[k]} = {1'b0, w_src_a[k][SEG-1:0]}
                                    - {1'b0, w_src_b[k][SEG-1:0]}
                                    - (SEG+1)'(w_src_bin[k]);

      assign w_a_next[k]   = w_src_a[k] >> SEG;
      assign w_b_next[k]   = w_src_b[k] >> SEG;
      assign w_res_next[k] = (w_src_res[k] >> SEG) | (WIDTH'(w_diff[k]) << (WIDTH - SEG));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_brw[i] <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_res[i] <= '0;
      end
    end else if (w_advance) begin
      // Bubbles advance like any other slot; their data is don't-care.
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= w_src_vld[i];
        r_brw[i] <= w_bout[i];
        r_a[i]   <= w_a_next[i];
        r_b[i]   <= w_b_next[i];
        r_res[i] <= w_res_next[i];
      end
    end
  end

  assign in_ready   = w_advance;
  assign out_valid  = r_vld[STAGES-1];
  assign o          = r_res[STAGES-1];
  assign borrow_out = r_brw[STAGES-1];

endmodule

// File: tb/tb_pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipelined_subtractor
//
// Testbench for pipelined_subtractor with WIDTH=16 and SEG=4 (latency 4).
// The driver presents operands shortly after a rising edge. Handshakes are
// sampled on the falling edge. An accepted pair pushes its hand-computed
// {borrow, o} into exp_q. The output monitor pops exp_q on each output
// transfer.
// -----------------------------------------------------------------------------
module tb_pipelined_subtractor;

  localparam int W   = 16;
  localparam int SEG = 4;
  localparam int LAT = W / SEG;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // DUT signals
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i       = '0;
  logic [W-1:0] b_i       = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] o;
  logic         borrow_out;

  pipelined_subtractor #(.WIDTH(W), .SEG(SEG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_i),
    .b          (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .o          (o),
    .borrow_out (borrow_out)
  );

  // Scoreboard state
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit rand_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] va, input logic [W-1:0] vb);
    logic [W-1:0] d;
    d = va - vb;
    return {(va < vb), d};
  endfunction

  // Output monitor: every output transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("o", 32'(o), 32'(mon_e[W-1:0]));
        check("borrow", 32'(borrow_out), 32'(mon_e[W]));
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W:0] ex);
    int  budget;
    bit  done;
    a_i      = va;
    b_i      = vb;
    in_valid = 1'b1;
    done     = 1'b0;
    budget   = 0;
    while (!done && budget < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ex);
        n_in++;
        done = 1'b1;
      end
      budget++;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check(tag, 32'(lat), 32'(LAT));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int stale;

    // Reset block
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", 32'(o), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle(1);

    // Basic op with latency measurement
    out_ready = 1'b1;
    send(16'h1234, 16'h0234, {1'b0, 16'h1000});
    measure_latency("latency_first");
    wait_drain("drain_basic");

    // Directed corner vectors (values hand-computed)
    send(16'h0000, 16'h0001, {1'b1, 16'hFFFF});  // borrow through all segments
    send(16'h8000, 16'h8000, {1'b0, 16'h0000});
    send(16'h7FFF, 16'h8000, {1'b1, 16'hFFFF});
    send(16'hFFFF, 16'h0001, {1'b0, 16'hFFFE});
    send(16'h0010, 16'h0001, {1'b0, 16'h000F});  // borrow from segment 1
    send(16'h1000, 16'h0FFF, {1'b0, 16'h0001});  // borrow across three segments
    wait_drain("drain_directed");

    // Back-to-back into a stalled output; hold for 3 cycles
    out_ready = 1'b0;
    send(16'h0005, 16'h0003, {1'b0, 16'h0002});
    send(16'h0100, 16'h0200, {1'b1, 16'hFF00});
    send(16'hABCD, 16'h1234, {1'b0, 16'h9999});
    send(16'h0000, 16'hFFFF, {1'b1, 16'h0001});
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_count_in", 32'(n_in), 32'd11);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold_o", 32'(o), 32'h0002);
      check("stall_hold_borrow", 32'(borrow_out), 32'd0);
      check("stall_hold_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("drain_stall");

    // Async reset with tokens in flight
    out_ready = 1'b0;
    send(16'h4444, 16'h1111, {1'b0, 16'h3333});
    send(16'h2222, 16'h3333, {1'b1, 16'hEEEF});
    send(16'h0F00, 16'h00F0, {1'b0, 16'h0E10});
    idle(2);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_o", 32'(o), 32'd0);
    check("async_rst_borrow", 32'(borrow_out), 32'd0);
    idle(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'h00F0, {1'b0, 16'h0E1F});
    measure_latency("latency_after_rst");
    wait_drain("drain_rst");

    // Random stream with bubbles and random backpressure
    n_in  = 0;
    n_out = 0;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      send(ra, rb, model(ra, rb));
    end
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("drain_random");
    check("count_in_eq_out", 32'(n_out), 32'(n_in));
    check("count_random_in", 32'(n_in), 32'd300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
